// File: rtl/axi_rd_reorder_buffer.sv
// rtl/axi_rd_reorder_buffer.sv - read-channel reorder buffer returning out-of-order R beats in AR issue order
// Tracks up to DEPTH single-beat reads in a ring; repeated IDs are matched oldest-first.
module axi_rd_reorder_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_arid_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  output logic [ID_WIDTH-1:0]   m_arid_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  input  logic [DATA_WIDTH-1:0] m_rdata_i,
  input  logic [1:0]            m_rresp_i,
  input  logic [ID_WIDTH-1:0]   m_rid_i,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic [1:0]            s_rresp_o,
  output logic [ID_WIDTH-1:0]   s_rid_o,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i,
  output logic [CNT_W-1:0]      count_o,
  output logic                  err_unexpected_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                  alloc_q  [DEPTH];
  logic                  filled_q [DEPTH];
  logic [ID_WIDTH-1:0]   id_q     [DEPTH];
  logic [1:0]            resp_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q   [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             m_rready_q;
  logic             err_q, err_d;

  logic             full;
  logic             ar_fire;
  logic             r_fire;
  logic             retire;
  logic             match_found;
  logic [PTR_W-1:0] match_idx;
  logic [PTR_W:0]   scan_sum;
  logic [PTR_W-1:0] scan_idx;

  // Full is judged from the registered count so a retire only frees a slot next cycle.
  assign full        = (count_q == CNT_W'(DEPTH));
  assign m_arvalid_o = s_arvalid_i & ~full;
  assign s_arready_o = m_arready_i & ~full;
  assign m_arid_o    = s_arid_i;
  assign ar_fire     = s_arvalid_i & s_arready_o;

  assign m_rready_o = m_rready_q;
  assign r_fire     = m_rvalid_i & m_rready_q;

  assign s_rvalid_o = alloc_q[rptr_q] & filled_q[rptr_q];
  assign s_rdata_o  = data_q[rptr_q];
  assign s_rresp_o  = resp_q[rptr_q];
  assign s_rid_o    = id_q[rptr_q];
  assign retire     = s_rvalid_o & s_rready_i;

  assign count_o          = count_q;
  assign err_unexpected_o = err_q;

  // Scan from the head in issue order; the first unfilled same-ID entry is the oldest.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_sum = {1'b0, rptr_q} + (PTR_W+1)'(i);
      if (scan_sum >= (PTR_W+1)'(DEPTH)) begin
        scan_sum = scan_sum - (PTR_W+1)'(DEPTH);
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (!match_found && alloc_q[scan_idx] && !filled_q[scan_idx] &&
          (id_q[scan_idx] == m_rid_i)) begin
        match_found = 1'b1;
        match_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    if (ar_fire) begin
      wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    end
    rptr_d = rptr_q;
    if (retire) begin
      rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    end
    count_d = count_q;
    case ({ar_fire, retire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    err_d = r_fire & ~match_found;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      m_rready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      m_rready_q <= 1'b1;
      err_q      <= err_d;
    end
  end

  // Alloc slot (wptr), fill slot (unfilled) and retire slot (filled head) are always distinct.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        alloc_q[i]  <= 1'b0;
        filled_q[i] <= 1'b0;
        id_q[i]     <= '0;
        resp_q[i]   <= '0;
        data_q[i]   <= '0;
      end
    end else begin
      if (ar_fire) begin
        alloc_q[wptr_q]  <= 1'b1;
        filled_q[wptr_q] <= 1'b0;
        id_q[wptr_q]     <= s_arid_i;
      end
      if (r_fire && match_found) begin
        filled_q[match_idx] <= 1'b1;
        resp_q[match_idx]   <= m_rresp_i;
        data_q[match_idx]   <= m_rdata_i;
      end
      if (retire) begin
        alloc_q[rptr_q]  <= 1'b0;
        filled_q[rptr_q] <= 1'b0;
        id_q[rptr_q]     <= '0;
        resp_q[rptr_q]   <= '0;
        data_q[rptr_q]   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_reorder_buffer.sv
// tb/tb_axi_rd_reorder_buffer.sv - table-driven check of the reorder buffer with DEPTH=4
module tb_axi_rd_reorder_buffer;

  localparam int DW    = 8;
  localparam int IW    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] s_arid_i;
  logic          s_arvalid_i;
  logic          s_arready_o;
  logic [IW-1:0] m_arid_o;
  logic          m_arvalid_o;
  logic          m_arready_i;
  logic [DW-1:0] m_rdata_i;
  logic [1:0]    m_rresp_i;
  logic [IW-1:0] m_rid_i;
  logic          m_rvalid_i;
  logic          m_rready_o;
  logic [DW-1:0] s_rdata_o;
  logic [1:0]    s_rresp_o;
  logic [IW-1:0] s_rid_o;
  logic          s_rvalid_o;
  logic          s_rready_i;
  logic [CW-1:0] count_o;
  logic          err_unexpected_o;

  axi_rd_reorder_buffer #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_arid_i(s_arid_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
    .m_arid_o(m_arid_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rid_i(m_rid_i),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
    .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rid_o(s_rid_o),
    .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
    .count_o(count_o), .err_unexpected_o(err_unexpected_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          arv;
    logic [IW-1:0] arid;
    logic          rv;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          srr;
    logic          e_arr;
    logic          e_rv;
    logic [IW-1:0] e_rid;
    logic [DW-1:0] e_rdata;
    logic [1:0]    e_rresp;
    logic [CW-1:0] e_cnt;
    logic          e_err;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic arv, input logic [IW-1:0] arid,
                              input logic rv, input logic [IW-1:0] rid,
                              input logic [DW-1:0] rdata, input logic [1:0] rresp,
                              input logic srr, input logic e_arr, input logic e_rv,
                              input logic [IW-1:0] e_rid, input logic [DW-1:0] e_rdata,
                              input logic [1:0] e_rresp, input logic [CW-1:0] e_cnt,
                              input logic e_err);
    vec_t v;
    v.arv = arv; v.arid = arid; v.rv = rv; v.rid = rid; v.rdata = rdata;
    v.rresp = rresp; v.srr = srr; v.e_arr = e_arr; v.e_rv = e_rv; v.e_rid = e_rid;
    v.e_rdata = e_rdata; v.e_rresp = e_rresp; v.e_cnt = e_cnt; v.e_err = e_err;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic arv, input logic [IW-1:0] arid, input logic rv,
                       input logic [IW-1:0] rid, input logic [DW-1:0] rdata,
                       input logic [1:0] rresp, input logic srr);
    s_arvalid_i = arv;
    s_arid_i    = arid;
    m_rvalid_i  = rv;
    m_rid_i     = rid;
    m_rdata_i   = rdata;
    m_rresp_i   = rresp;
    s_rready_i  = srr;
  endtask

  initial begin
    // in-order: IDs 1,2,3 returned in order
    add(1,1, 0,0,8'h00,0, 1, 1,0,0,8'h00,0, 0,0);
    add(1,2, 0,0,8'h00,0, 1, 1,0,0,8'h00,0, 1,0);
    add(1,3, 0,0,8'h00,0, 1, 1,0,0,8'h00,0, 2,0);
    add(0,0, 1,1,8'h11,0, 1, 1,0,0,8'h00,0, 3,0);
    add(0,0, 1,2,8'h22,1, 1, 1,1,1,8'h11,0, 3,0);
    add(0,0, 1,3,8'h33,2, 1, 1,1,2,8'h22,1, 2,0);
    add(0,0, 0,0,8'h00,0, 1, 1,1,3,8'h33,2, 1,0);
    add(0,0, 0,0,8'h00,0, 1, 1,0,0,8'h00,0, 0,0);
    // reorder: 5,6,7 returned 7,5,6; one stall cycle on the upstream side
    add(1,5, 0,0,8'h00,0, 1, 1,0,0,8'h00,0, 0,0);
    add(1,6, 0,0,8'h00,0, 1, 1,0,0,8'h00,0, 1,0);
    add(1,7, 0,0,8'h00,0, 1, 1,0,0,8'h00,0, 2,0);
    add(0,0, 1,7,8'hA7,0, 1, 1,0,0,8'h00,0, 3,0);
    add(0,0, 1,5,8'hA5,3, 1, 1,0,0,8'h00,0, 3,0);
    add(0,0, 1,6,8'hA6,1, 0, 1,1,5,8'hA5,3, 3,0);
    add(0,0, 0,0,8'h00,0, 1, 1,1,5,8'hA5,3, 3,0);
    add(0,0, 0,0,8'h00,0, 1, 1,1,6,8'hA6,1, 2,0);
    add(0,0, 0,0,8'h00,0, 1, 1,1,7,8'hA7,0, 1,0);
    add(0,0, 0,0,8'h00,0, 1, 1,0,0,8'h00,0, 0,0);
    // same ID twice: 3,3,4 returned 4,3,3
    add(1,3, 0,0,8'h00,0, 1, 1,0,0,8'h00,0, 0,0);
    add(1,3, 0,0,8'h00,0, 1, 1,0,0,8'h00,0, 1,0);
    add(1,4, 0,0,8'h00,0, 1, 1,0,0,8'h00,0, 2,0);
    add(0,0, 1,4,8'h44,0, 1, 1,0,0,8'h00,0, 3,0);
    add(0,0, 1,3,8'h01,0, 1, 1,0,0,8'h00,0, 3,0);
    add(0,0, 1,3,8'h02,0, 1, 1,1,3,8'h01,0, 3,0);
    add(0,0, 0,0,8'h00,0, 1, 1,1,3,8'h02,0, 2,0);
    add(0,0, 0,0,8'h00,0, 1, 1,1,4,8'h44,0, 1,0);
    add(0,0, 0,0,8'h00,0, 1, 1,0,0,8'h00,0, 0,0);
    // unknown ID 9
    add(0,0, 1,9,8'hEE,0, 1, 1,0,0,8'h00,0, 0,0);
    add(0,0, 0,0,8'h00,0, 1, 1,0,0,8'h00,0, 0,1);
    add(0,0, 0,0,8'h00,0, 1, 1,0,0,8'h00,0, 0,0);
    // duplicate response for an already-filled ID is dropped
    add(1,2, 0,0,8'h00,0, 0, 1,0,0,8'h00,0, 0,0);
    add(0,0, 1,2,8'h5A,0, 0, 1,0,0,8'h00,0, 1,0);
    add(0,0, 1,2,8'h5B,0, 0, 1,1,2,8'h5A,0, 1,0);
    add(0,0, 0,0,8'h00,0, 1, 1,1,2,8'h5A,0, 1,1);
    add(0,0, 0,0,8'h00,0, 1, 1,0,0,8'h00,0, 0,0);
    // full: 5th AR stalls until a retire, slot reopens the next cycle
    add(1,1, 0,0,8'h00,0, 0, 1,0,0,8'h00,0, 0,0);
    add(1,2, 0,0,8'h00,0, 0, 1,0,0,8'h00,0, 1,0);
    add(1,3, 0,0,8'h00,0, 0, 1,0,0,8'h00,0, 2,0);
    add(1,4, 0,0,8'h00,0, 0, 1,0,0,8'h00,0, 3,0);
    add(1,5, 0,0,8'h00,0, 0, 0,0,0,8'h00,0, 4,0);
    add(1,5, 1,1,8'h61,0, 0, 0,0,0,8'h00,0, 4,0);
    add(1,5, 0,0,8'h00,0, 1, 0,1,1,8'h61,0, 4,0);
    add(1,5, 0,0,8'h00,0, 0, 1,0,0,8'h00,0, 3,0);
    add(0,0, 0,0,8'h00,0, 0, 0,0,0,8'h00,0, 4,0);

    rst = 1'b1;
    m_arready_i = 1'b1;
    drive(0, 0, 0, 0, 8'h00, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_count", 32'(count_o), 0);
    chk("reset_rvalid", 32'(s_rvalid_o), 0);
    chk("reset_rready", 32'(m_rready_o), 0);
    chk("reset_err", 32'(err_unexpected_o), 0);
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k].arv, vecs[k].arid, vecs[k].rv, vecs[k].rid, vecs[k].rdata,
            vecs[k].rresp, vecs[k].srr);
      #1;
      chk($sformatf("v%0d_count", k), 32'(count_o), 32'(vecs[k].e_cnt));
      chk($sformatf("v%0d_s_arready", k), 32'(s_arready_o), 32'(vecs[k].e_arr));
      chk($sformatf("v%0d_m_arvalid", k), 32'(m_arvalid_o), 32'(vecs[k].arv & vecs[k].e_arr));
      chk($sformatf("v%0d_m_arid", k), 32'(m_arid_o), 32'(vecs[k].arid));
      chk($sformatf("v%0d_m_rready", k), 32'(m_rready_o), 1);
      chk($sformatf("v%0d_err", k), 32'(err_unexpected_o), 32'(vecs[k].e_err));
      chk($sformatf("v%0d_s_rvalid", k), 32'(s_rvalid_o), 32'(vecs[k].e_rv));
      if (vecs[k].e_rv) begin
        chk($sformatf("v%0d_s_rid", k), 32'(s_rid_o), 32'(vecs[k].e_rid));
        chk($sformatf("v%0d_s_rdata", k), 32'(s_rdata_o), 32'(vecs[k].e_rdata));
        chk($sformatf("v%0d_s_rresp", k), 32'(s_rresp_o), 32'(vecs[k].e_rresp));
      end
    end

    // reset mid-flight: four outstanding (2,3,4,5), head ID 2 gets filled first
    @(negedge clk);
    drive(0, 0, 1, 2, 8'h77, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 8'h00, 0, 0);
    #1;
    chk("prerst_rvalid", 32'(s_rvalid_o), 1);
    chk("prerst_rdata", 32'(s_rdata_o), 32'h77);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_rvalid", 32'(s_rvalid_o), 0);
    chk("midrst_rdata", 32'(s_rdata_o), 0);
    chk("midrst_rid", 32'(s_rid_o), 0);
    chk("midrst_count", 32'(count_o), 0);
    chk("midrst_rready", 32'(m_rready_o), 0);
    chk("midrst_err", 32'(err_unexpected_o), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(0, 0, 1, 3, 8'h99, 0, 0);
    #1;
    chk("late_rready", 32'(m_rready_o), 1);
    chk("late_err_pre", 32'(err_unexpected_o), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 8'h00, 0, 0);
    #1;
    chk("late_err", 32'(err_unexpected_o), 1);
    chk("late_count", 32'(count_o), 0);
    chk("late_rvalid", 32'(s_rvalid_o), 0);
    @(negedge clk);
    #1;
    chk("late_err_clear", 32'(err_unexpected_o), 0);

    // downstream not ready: upstream sees no ready, nothing allocated
    @(negedge clk);
    m_arready_i = 1'b0;
    drive(1, 8, 0, 0, 8'h00, 0, 0);
    #1;
    chk("noready_s_arready", 32'(s_arready_o), 0);
    chk("noready_m_arvalid", 32'(m_arvalid_o), 1);
    @(negedge clk);
    m_arready_i = 1'b1;
    drive(0, 0, 0, 0, 8'h00, 0, 0);
    #1;
    chk("noready_count", 32'(count_o), 0);

    // alloc and retire in the same cycle keep count unchanged
    @(negedge clk);
    drive(1, 8, 0, 0, 8'h00, 0, 0);
    @(negedge clk);
    drive(0, 0, 1, 8, 8'h88, 2, 0);
    #1;
    chk("both_count_pre", 32'(count_o), 1);
    @(negedge clk);
    drive(1, 9, 0, 0, 8'h00, 0, 1);
    #1;
    chk("both_rvalid", 32'(s_rvalid_o), 1);
    chk("both_rdata", 32'(s_rdata_o), 32'h88);
    chk("both_rresp", 32'(s_rresp_o), 2);
    @(negedge clk);
    drive(0, 0, 0, 0, 8'h00, 0, 0);
    #1;
    chk("both_count_post", 32'(count_o), 1);
    chk("both_rvalid_post", 32'(s_rvalid_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
